// File: rtl/romulator_pkg.sv
// Shared definitions for the SPI RAM loader.
//   CMD_WRITE / CMD_READ : host command bytes
//   SPI_SYNC_STAGES      : synchroniser depth for the asynchronous SPI inputs
//   loader_state_e       : loader state machine encoding
package romulator_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    localparam int unsigned SPI_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddrH,
        StAddrL,
        StWdata,
        StRdata,
        StIgnore,
        StAccess
    } loader_state_e;

endpackage

// File: rtl/spi_ram_loader_if.sv
// Byte-wide RAM port driven by the loader.
//   master : loader side (drives address, write data, strobes, ownership)
//   slave  : RAM / mux side (returns read data)
interface spi_ram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16
) ();

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [7:0]            ram_datain;
    logic [7:0]            ram_dataa;
    logic                  ram_cs_n;
    logic                  ram_we_n;
    logic                  ram_own;

    modport master (
        output ram_address,
        output ram_datain,
        output ram_cs_n,
        output ram_we_n,
        output ram_own,
        input  ram_dataa
    );

    modport slave (
        input  ram_address,
        input  ram_datain,
        input  ram_cs_n,
        input  ram_we_n,
        input  ram_own,
        output ram_dataa
    );

endinterface

// File: rtl/spi_sync.sv
// Synchroniser plus edge detector for one asynchronous SPI input.
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : asynchronous input
//   level_o    : synchronised level
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
module spi_sync
    import romulator_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SPI_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SPI_SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SPI_SYNC_STAGES-1];
    end

    // Reset to 0: a chip select already held low across reset then shows no
    // falling edge, so the loader waits for a fresh transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[SPI_SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_ram_loader.sv
// SPI-slave (mode 0) front end that writes and reads back a byte-wide RAM.
//   clk, reset             : system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi     : asynchronous SPI inputs from the host
//   spi_miso               : serial read-back data, MSB first
//   ram                    : RAM port (address, data, active-low strobes, ownership)
// Transaction: command byte, address high, address low, then data bytes.
module spi_ram_loader
    import romulator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    spi_ram_loader_if.master     ram
);

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("spi_ram_loader: DATA_WIDTH must be 8");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_addr_width
        $error("spi_ram_loader: ADDR_WIDTH must be 1..16");
    end

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync u_sync_sclk (
        .clk(clk), .reset(reset), .d_i(spi_sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync u_sync_cs (
        .clk(clk), .reset(reset), .d_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync u_sync_mosi (
        .clk(clk), .reset(reset), .d_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_edges = ^{sclk_lvl, cs_rise, mosi_rise, mosi_fall};

    loader_state_e         state_q, state_d, ret_q, ret_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            tx_q, tx_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cmd_rd_q, cmd_rd_d;
    logic                  access_rd_q, access_rd_d;
    logic                  cs_n_q, cs_n_d;
    logic                  we_n_q, we_n_d;
    logic [7:0]            datain_q, datain_d;
    logic                  own_q, own_d;
    logic                  miso_q, miso_d;

    logic [7:0]            rx_byte;
    logic [15:0]           addr_full;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        cmd_rd_d    = cmd_rd_q;
        access_rd_d = access_rd_q;
        cs_n_d      = 1'b1;
        we_n_d      = 1'b1;
        datain_d    = 8'h00;
        rx_byte     = {shift_q[6:0], mosi_lvl};
        addr_full   = {addr_hi_q, rx_byte};

        case (state_q)
            StIdle: begin
                bit_cnt_d = 3'd0;
                tx_d      = 8'h00;
                if (cs_fall) state_d = StCmd;
            end
            // Strobe cycle: RAM samples on the negedge, so read data is ready here.
            StAccess: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (access_rd_q) tx_d = ram.ram_dataa;
                state_d = cs_lvl ? StIdle : ret_q;
            end
            default: begin
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = rx_byte;
                end
                // The falling edge that closes bit 0 must not shift out a freshly
                // loaded MSB, so only falls inside a byte shift.
                if (sclk_fall && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
                if (sclk_rise && bit_cnt_q == 3'd7) begin
                    case (state_q)
                        StCmd: begin
                            if (rx_byte == CMD_WRITE) begin
                                cmd_rd_d = 1'b0;
                                state_d  = StAddrH;
                            end else if (rx_byte == CMD_READ) begin
                                cmd_rd_d = 1'b1;
                                state_d  = StAddrH;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                        StAddrH: begin
                            addr_hi_d = rx_byte;
                            state_d   = StAddrL;
                        end
                        StAddrL: begin
                            addr_d = addr_full[ADDR_WIDTH-1:0];
                            if (cmd_rd_q) begin
                                state_d     = StAccess;
                                ret_d       = StRdata;
                                access_rd_d = 1'b1;
                                cs_n_d      = 1'b0;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                        StWdata: begin
                            state_d     = StAccess;
                            ret_d       = StWdata;
                            access_rd_d = 1'b0;
                            cs_n_d      = 1'b0;
                            we_n_d      = 1'b0;
                            datain_d    = rx_byte;
                        end
                        StRdata: begin
                            state_d     = StAccess;
                            ret_d       = StRdata;
                            access_rd_d = 1'b1;
                            cs_n_d      = 1'b0;
                        end
                        default: ;
                    endcase
                end
                // A byte completing alongside cs_n rising is still committed.
                if (cs_lvl) begin
                    if (state_d == StAccess) ret_d = StIdle;
                    else                     state_d = StIdle;
                end
            end
        endcase

        own_d  = (state_d != StIdle);
        miso_d = (state_d == StRdata || (state_d == StAccess && ret_d == StRdata)) ?
                 tx_d[7] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ret_q       <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            addr_hi_q   <= 8'h00;
            addr_q      <= '0;
            cmd_rd_q    <= 1'b0;
            access_rd_q <= 1'b0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            datain_q    <= 8'h00;
            own_q       <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            cmd_rd_q    <= cmd_rd_d;
            access_rd_q <= access_rd_d;
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            datain_q    <= datain_d;
            own_q       <= own_d;
            miso_q      <= miso_d;
        end
    end

    assign ram.ram_address = addr_q;
    assign ram.ram_datain  = datain_q;
    assign ram.ram_cs_n    = cs_n_q;
    assign ram.ram_we_n    = we_n_q;
    assign ram.ram_own     = own_q;
    assign spi_miso        = miso_q;

endmodule

// File: tb/tb_spi_ram_loader.sv
// Scoreboard bench for spi_ram_loader: a host model drives SPI at clk/8, a RAM
// model answers the strobes, and monitors compare writes and read-back bytes
// against queues of hand-computed expectations.
module tb_spi_ram_loader;

    logic clk = 1'b0;
    logic reset;
    logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;

    spi_ram_loader_if #(.ADDR_WIDTH(16)) ram_bus ();

    spi_ram_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .ram(ram_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        wr_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] mem [0:65535];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cs_pulses = 0;
    int we_pulses = 0;
    int miso_bad = 0;
    bit prev_cs_low = 1'b0;
    bit chk_miso_zero = 1'b0;
    bit rd_window = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    int rx_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM model: samples strobes on the negedge.
    always @(negedge clk) begin
        if (!ram_bus.ram_cs_n) begin
            if (!ram_bus.ram_we_n) mem[ram_bus.ram_address] <= ram_bus.ram_datain;
            else                   ram_bus.ram_dataa <= mem[ram_bus.ram_address];
        end
    end

    // Strobe monitor: pops expected writes, checks pulse width and read datain.
    always @(negedge clk) begin
        if (!reset) begin
            if (!ram_bus.ram_cs_n) begin
                cs_pulses++;
                check("strobe_width", {31'd0, prev_cs_low}, 32'd0);
                if (!ram_bus.ram_we_n) begin
                    we_pulses++;
                    if (wr_exp_q.size() == 0) begin
                        check("unexpected_write", {16'd0, ram_bus.ram_address}, 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = wr_exp_q.pop_front();
                        check("wr_addr", {16'd0, ram_bus.ram_address}, {16'd0, e.a});
                        check("wr_data", {24'd0, ram_bus.ram_datain}, {24'd0, e.d});
                    end
                end else begin
                    check("rd_datain", {24'd0, ram_bus.ram_datain}, 32'd0);
                end
            end
            if (chk_miso_zero && spi_miso) miso_bad++;
        end
        prev_cs_low = !ram_bus.ram_cs_n && !reset;
    end

    // Read-back monitor: host samples miso on each sclk rise inside the read window.
    always @(posedge spi_sclk) begin
        if (rd_window) begin
            rx_sh = {rx_sh[6:0], spi_miso};
            rx_n++;
            if (rx_n == 8) begin
                rx_n = 0;
                if (rd_exp_q.size() == 0) check("unexpected_read", {24'd0, rx_sh}, 32'hFFFF_FFFF);
                else check("rd_byte", {24'd0, rx_sh}, {24'd0, rd_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int p0;
        foreach (mem[i]) mem[i] = 8'h00;
        ram_bus.ram_dataa = 8'h00;
        reset    = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_cs_n",   {31'd0, ram_bus.ram_cs_n}, 32'd1);
        check("rst_we_n",   {31'd0, ram_bus.ram_we_n}, 32'd1);
        check("rst_addr",   {16'd0, ram_bus.ram_address}, 32'd0);
        check("rst_datain", {24'd0, ram_bus.ram_datain}, 32'd0);
        check("rst_miso",   {31'd0, spi_miso}, 32'd0);
        check("rst_own",    {31'd0, ram_bus.ram_own}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic two-byte write.
        p0 = we_pulses;
        wr_exp_q.push_back('{a: 16'h1234, d: 8'hAA});
        wr_exp_q.push_back('{a: 16'h1235, d: 8'h55});
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h12); spi_byte(8'h34);
        check("own_during_write", {31'd0, ram_bus.ram_own}, 32'd1);
        spi_byte(8'hAA); spi_byte(8'h55);
        cs_end();
        check("write_pulses", we_pulses - p0, 32'd2);
        check("mem_1234", {24'd0, mem[16'h1234]}, 32'hAA);
        check("mem_1235", {24'd0, mem[16'h1235]}, 32'h55);
        check("own_after_write", {31'd0, ram_bus.ram_own}, 32'd0);

        // Read with address wrap.
        mem[16'hFFFE] = 8'h11;
        mem[16'hFFFF] = 8'h22;
        mem[16'h0000] = 8'h33;
        rd_exp_q.push_back(8'h11);
        rd_exp_q.push_back(8'h22);
        rd_exp_q.push_back(8'h33);
        cs_begin();
        spi_byte(8'h03); spi_byte(8'hFF); spi_byte(8'hFE);
        rd_window = 1'b1;
        repeat (3) spi_byte(8'h00);
        rd_window = 1'b0;
        cs_end();

        // Unknown command is ignored.
        p0 = cs_pulses;
        miso_bad = 0;
        cs_begin();
        chk_miso_zero = 1'b1;
        spi_byte(8'h7E);
        spi_byte(8'hFF); spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'hFF);
        check("own_in_ignore", {31'd0, ram_bus.ram_own}, 32'd1);
        cs_end();
        chk_miso_zero = 1'b0;
        check("ignore_no_strobe", cs_pulses - p0, 32'd0);
        check("ignore_miso_zero", miso_bad, 32'd0);
        check("ignore_own_drop", {31'd0, ram_bus.ram_own}, 32'd0);

        // Partial data byte is discarded; a following full write succeeds.
        p0 = cs_pulses;
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h10);
        spi_bits(8'h99, 5);
        cs_end();
        check("partial_no_strobe", cs_pulses - p0, 32'd0);
        check("partial_idle_own", {31'd0, ram_bus.ram_own}, 32'd0);
        check("partial_mem", {24'd0, mem[16'h0010]}, 32'h00);
        wr_exp_q.push_back('{a: 16'h0010, d: 8'h77});
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h10); spi_byte(8'h77);
        cs_end();
        check("retry_mem", {24'd0, mem[16'h0010]}, 32'h77);

        // Reset in the middle of the second data byte.
        wr_exp_q.push_back('{a: 16'h0040, d: 8'hAB});
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h40); spi_byte(8'hAB);
        spi_bits(8'hCD, 4);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_cs_n", {31'd0, ram_bus.ram_cs_n}, 32'd1);
        check("rst_mid_we_n", {31'd0, ram_bus.ram_we_n}, 32'd1);
        check("rst_mid_own",  {31'd0, ram_bus.ram_own}, 32'd0);
        check("rst_mid_addr", {16'd0, ram_bus.ram_address}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            spi_mosi = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        spi_byte(8'hEE);
        check("rst_lost_own", {31'd0, ram_bus.ram_own}, 32'd0);
        cs_end();
        check("rst_mem_40", {24'd0, mem[16'h0040]}, 32'hAB);
        check("rst_mem_41", {24'd0, mem[16'h0041]}, 32'h00);

        // 256-byte write then read-back at clk/8.
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h01); spi_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = 8'(i * 7 + 3);
            wr_exp_q.push_back('{a: 16'h0100 + 16'(i), d: d});
            spi_byte(d);
        end
        cs_end();
        cs_begin();
        spi_byte(8'h03); spi_byte(8'h01); spi_byte(8'h00);
        rd_window = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rd_exp_q.push_back(8'(i * 7 + 3));
            spi_byte(8'h00);
        end
        rd_window = 1'b0;
        cs_end();

        check("wr_queue_drained", wr_exp_q.size(), 32'd0);
        check("rd_queue_drained", rd_exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
